lanzador_cubos: RTL
===================

LANZADOR_CUBOS -- requirements
Module: lanzador_cubos

Interface
REQ-001 Parameters SHALL be: NUM_SLOTS, 4, number of cubes served (fixed, not overridable); SEMILLA, 9'h1A5, LFSR reset value (nonzero).
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-004 enable  in  1  high = launching allowed; low = no new launches.
REQ-005 pixel_x  in  10  current scan column from the video controller.
REQ-006 pixel_y  in  10  current scan row from the video controller.
REQ-007 terminado_cubo  in  4  per-slot one-cycle "cube reached bottom" pulses.
REQ-008 start_cubo  out  4  per-slot one-cycle launch pulse, at most one bit high.
REQ-009 posicion_x_aleatoria  out  9  launch X position, shared by all slots.
REQ-010 velocidad_cubo  out  2  launch speed, shared by all slots.
REQ-011 cubos_activos  out  4  bit i high while slot i is falling.
REQ-012 cubos_completados  out  8  saturating count of finished cubes.
REQ-013 nivel  out  2  difficulty level.

Function
REQ-014 Frame tick SHALL be a one-clk pulse on the rising edge of (pixel_y==481 && pixel_x==0), detected with one registered copy of the condition.
REQ-015 A 9-bit Fibonacci LFSR SHALL be used: taps x^9+x^5+1, advanced every clk, never zero.
REQ-016 FSM states SHALL be ESPERA and LANZA; an undefined encoding SHALL go to ESPERA.
REQ-017 In ESPERA, a 7-bit frame counter SHALL increment on each tick and saturate at 127.
REQ-018 ESPERA->LANZA SHALL occur when enable=1, counter>=intervalo and any cubos_activos bit is 0; otherwise the FSM SHALL stay in ESPERA, keeping the launch pending.
REQ-019 On the ESPERA->LANZA transition, posicion_x_aleatoria SHALL register the LFSR value and velocidad_cubo SHALL register the selected speed; both SHALL hold until the next launch.
REQ-020 LANZA SHALL last exactly one cycle, with start_cubo bit set for the lowest-index free slot; that cubos_activos bit SHALL set at the end of the cycle, the counter SHALL clear and the FSM SHALL return to ESPERA.
REQ-021 terminado_cubo[i]=1 SHALL clear cubos_activos[i] the next cycle; a pulse on an inactive slot SHALL be ignored and not counted.
REQ-022 Valid pulses arriving in the same cycle SHALL all be counted: cubos_completados SHALL increase by their popcount, saturating at 255.
REQ-023 nivel SHALL equal min(3, cubos_completados>>4).
REQ-024 intervalo SHALL be 60/45/30/20 frames for nivel 0/1/2/3.
REQ-025 Default speed SHALL be 1/1/2/3 for nivel 0/1/2/3; velocidad_cubo SHALL never be 0 at a launch.
REQ-026 enable=0 SHALL force ESPERA with counter held at 0; slot tracking and counting SHALL continue.
REQ-027 A slot freed and a launch decided in the same cycle SHALL use only the pre-update cubos_activos; the freed slot becomes eligible the following cycle.

Reset
REQ-028 Reset SHALL force: FSM=ESPERA, counter=0, LFSR=SEMILLA, edge register=0, start_cubo=0, cubos_activos=0, cubos_completados=0, nivel=0, posicion_x_aleatoria=0, velocidad_cubo=1.
REQ-029 Reset asserted during LANZA SHALL suppress start_cubo in that same cycle's registered output; no slot is marked active.

Configuration
REQ-030 With LANZADOR_CUBOS_VEL_ALEATORIA_EN defined, velocidad_cubo SHALL be LFSR[1:0] at launch, replaced by 1 when zero, and the nivel table SHALL not affect speed; without the macro, REQ-025 applies.

Verification
REQ-031 Reset, enable=1, 60 frame ticks -> a single start_cubo=4'b0001 pulse, then cubos_activos=4'b0001, velocidad_cubo=1.
REQ-032 All 4 slots active, interval elapsed -> no start pulse; terminado_cubo=4'b0100 -> start_cubo=4'b0100 within 2 cycles.
REQ-033 terminado_cubo=4'b1011 with all slots active -> cubos_completados +3 and cubos_activos=4'b0100.
REQ-034 Drive 16 completions -> nivel=1, next launch after 45 ticks with velocidad_cubo=1; after 48 completions -> nivel=3, interval 20, velocidad_cubo=3.
REQ-035 pixel_y=481, pixel_x=0 held for 5 clk -> exactly one tick counted; enable dropped at tick 59 -> counter=0, no launch.
REQ-036 Reset pulsed mid-run -> all outputs return to REQ-028 values the next cycle, and the LFSR sequence restarts at 9'h1A5.

Source files
------------

// File: rtl/lanzador_cubos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lanzador_cubos: frame-paced cube launcher over four falling-cube slots.    |
// | Optional LANZADOR_CUBOS_VEL_ALEATORIA_EN: launch speed taken from the LFSR.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lanzador_cubos #(
    parameter logic [8:0] SEMILLA = 9'h1A5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [3:0] terminado_cubo,
    output logic [3:0] start_cubo,
    output logic [8:0] posicion_x_aleatoria,
    output logic [1:0] velocidad_cubo,
    output logic [3:0] cubos_activos,
    output logic [7:0] cubos_completados,
    output logic [1:0] nivel
);

    localparam int         NUM_SLOTS  = 4;
    localparam logic [9:0] FILA_TICK  = 10'd481;
    localparam logic [6:0] CONT_MAX   = 7'd127;

    typedef enum logic [1:0] {
        ESPERA = 2'b00,
        LANZA  = 2'b01
    } estado_t;

    estado_t                estado;
    logic [6:0]             contador;
    logic [8:0]             lfsr;
    logic                   cond_q;

    logic                   cond;
    logic                   tick;
    logic [6:0]             intervalo;
    logic [1:0]             velocidad_sel;
    logic [NUM_SLOTS-1:0]   libres;
    logic [NUM_SLOTS-1:0]   slot_sel;
    logic                   hay_libre;
    logic [NUM_SLOTS-1:0]   validos;
    logic [NUM_SLOTS-1:0]   marca_lanza;
    logic [2:0]             pop_validos;
    logic [8:0]             suma;

    assign cond      = (pixel_y == FILA_TICK) && (pixel_x == 10'd0);
    assign tick      = cond && !cond_q;
    assign libres    = ~cubos_activos;
    assign hay_libre = |libres;
    // Isolates the lowest set bit: lowest-index free slot as a one-hot.
    assign slot_sel  = libres & (~libres + 4'd1);
    assign validos   = terminado_cubo & cubos_activos;
    assign marca_lanza = (estado == LANZA) ? start_cubo : '0;
    assign suma      = {1'b0, cubos_completados} + {6'd0, pop_validos};
    assign nivel     = (cubos_completados[7:6] != 2'b00) ? 2'd3 : cubos_completados[5:4];

    always_comb begin
        pop_validos = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pop_validos = pop_validos + {2'd0, validos[i]};
        end
    end

    always_comb begin
        intervalo = 7'd60;
        case (nivel)
            2'd0:    intervalo = 7'd60;
            2'd1:    intervalo = 7'd45;
            2'd2:    intervalo = 7'd30;
            default: intervalo = 7'd20;
        endcase
    end

`ifdef LANZADOR_CUBOS_VEL_ALEATORIA_EN
    assign velocidad_sel = (lfsr[1:0] == 2'd0) ? 2'd1 : lfsr[1:0];
`else
    always_comb begin
        velocidad_sel = 2'd1;
        case (nivel)
            2'd0, 2'd1: velocidad_sel = 2'd1;
            2'd2:       velocidad_sel = 2'd2;
            default:    velocidad_sel = 2'd3;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado               <= ESPERA;
            contador             <= 7'd0;
            lfsr                 <= SEMILLA;
            cond_q               <= 1'b0;
            start_cubo           <= '0;
            cubos_activos        <= '0;
            cubos_completados    <= 8'd0;
            posicion_x_aleatoria <= 9'd0;
            velocidad_cubo       <= 2'd1;
        end else begin
            cond_q            <= cond;
            lfsr              <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
            // Launch decisions read the pre-update occupancy, so a slot freed this cycle waits one cycle.
            cubos_activos     <= (cubos_activos & ~validos) | marca_lanza;
            cubos_completados <= suma[8] ? 8'hFF : suma[7:0];
            start_cubo        <= '0;

            case (estado)
                ESPERA: begin
                    if (!enable) begin
                        contador <= 7'd0;
                    end else begin
                        if (tick && (contador != CONT_MAX)) begin
                            contador <= contador + 7'd1;
                        end
                        if ((contador >= intervalo) && hay_libre) begin
                            estado               <= LANZA;
                            start_cubo           <= slot_sel;
                            posicion_x_aleatoria <= lfsr;
                            velocidad_cubo       <= velocidad_sel;
                        end
                    end
                end
                LANZA: begin
                    contador <= 7'd0;
                    estado   <= ESPERA;
                end
                default: begin
                    contador <= 7'd0;
                    estado   <= ESPERA;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
